// File: rtl/trap_ctrl_pkg.sv
// Shared CSR addresses, cause codes and mstatus field helpers for the trap sequencer.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_MTIMER  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;

  // All machine-mode mstatus fields live in bits 12:0; upper bits pass through untouched.
  function automatic logic [12:0] ms_trap(input logic [12:0] st);
    logic [12:0] r;
    r = st;
    r[MS_MPIE] = st[MS_MIE];
    r[MS_MIE] = 1'b0;
    r[MS_MPP_LO +: 2] = 2'b11;
    return r;
  endfunction

  function automatic logic [12:0] ms_mret(input logic [12:0] st);
    logic [12:0] r;
    r = st;
    r[MS_MIE] = st[MS_MPIE];
    r[MS_MPIE] = 1'b1;
    r[MS_MPP_LO +: 2] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational trap priority encoder: irq > illegal > ecall > ebreak > mret.
module trap_prio
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                i_irq,
  input  logic                i_illegal,
  input  logic                i_ecall,
  input  logic                i_ebreak,
  input  logic                i_mret,
  output logic                o_take,
  output logic                o_is_mret,
  output logic [DATA_LEN-1:0] o_cause
);

  logic       w_intr;
  logic [3:0] w_code;

  always_comb begin
    o_take    = 1'b1;
    o_is_mret = 1'b0;
    w_intr    = 1'b0;
    w_code    = 4'd0;
    if (i_irq) begin
      w_intr = 1'b1;
      w_code = CAUSE_MTIMER;
    end else if (i_illegal) begin
      w_code = CAUSE_ILLEGAL;
    end else if (i_ecall) begin
      w_code = CAUSE_ECALL;
    end else if (i_ebreak) begin
      w_code = CAUSE_EBREAK;
    end else if (i_mret) begin
      o_is_mret = 1'b1;
    end else begin
      o_take = 1'b0;
    end
  end

  assign o_cause = {w_intr, {(DATA_LEN-5){1'b0}}, w_code};

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes traps/mret at an instruction boundary, walks the
// CSR read/modify/write sequence on the csr port, then issues a single PC redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  input  logic [DATA_LEN-1:0] inst_pc,
  input  logic                ecall,
  input  logic                ebreak,
  input  logic                illegal_inst,
  input  logic                mret,
  input  logic                timer_irq,
  input  logic                sw_csr_wen,
  input  logic [11:0]         sw_csr_addr,
  input  logic [DATA_LEN-1:0] sw_csr_wdata,
  output logic                csr_own,
  output logic                unusual_flag,
  output logic [DATA_LEN-1:0] cause,
  output logic [DATA_LEN-1:0] epc,
  output logic                csr_ren,
  output logic                csr_wen,
  output logic [11:0]         csr_addr,
  output logic [DATA_LEN-1:0] csr_wdata,
  input  logic [DATA_LEN-1:0] csr_rdata,
  output logic                stall,
  output logic                redirect_valid,
  output logic [DATA_LEN-1:0] redirect_pc
);

  // state     | meaning
  // S_IDLE    | pipeline owns csr port, waiting for a trap/mret at inst boundary
  // S_T_ENTER | trap strobe: csr latches mepc/mcause, we latch mtvec
  // S_T_RDST  | read mstatus
  // S_T_WRST  | write mstatus with MPIE<=MIE, MIE<=0, MPP<=M
  // S_M_RDEPC | mret: read mepc
  // S_M_RDST  | mret: read mstatus
  // S_M_WRST  | mret: write mstatus with MIE<=MPIE, MPIE<=1, MPP<=M
  // S_REDIR   | one-cycle PC redirect, then back to idle
  typedef enum logic [2:0] {
    S_IDLE, S_T_ENTER, S_T_RDST, S_T_WRST, S_M_RDEPC, S_M_RDST, S_M_WRST, S_REDIR
  } state_t;

  state_t              r_state;
  logic                r_mie;
  logic [DATA_LEN-1:0] r_tvec, r_epc_q, r_st;
  logic                r_own, r_unusual, r_ren, r_wen, r_redir;
  logic [11:0]         r_addr;
  logic [DATA_LEN-1:0] r_wdata, r_cause, r_epc, r_rpc;

  logic                w_take, w_is_mret, w_accept;
  logic [DATA_LEN-1:0] w_cause;
  logic                w_unused;

  trap_prio #(.DATA_LEN(DATA_LEN)) u_prio (
    .i_irq     (inst_valid & timer_irq & r_mie),
    .i_illegal (inst_valid & illegal_inst),
    .i_ecall   (inst_valid & ecall),
    .i_ebreak  (inst_valid & ebreak),
    .i_mret    (inst_valid & mret),
    .o_take    (w_take),
    .o_is_mret (w_is_mret),
    .o_cause   (w_cause)
  );

  assign w_accept = (r_state == S_IDLE) & w_take;
  assign w_unused = ^{r_tvec[1:0], sw_csr_wdata, r_st};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mie     <= 1'b0;
      r_tvec    <= '0;
      r_epc_q   <= '0;
      r_st      <= '0;
      r_own     <= 1'b0;
      r_unusual <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_redir   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cause   <= '0;
      r_epc     <= '0;
      r_rpc     <= '0;
    end else begin
      r_unusual <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_redir   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cause   <= '0;
      r_epc     <= '0;
      r_rpc     <= '0;
      case (r_state)
        S_IDLE: begin
          // Snoop updates mie only after this cycle's accept decision has used the old value.
          if (sw_csr_wen && sw_csr_addr == CSR_MSTATUS) r_mie <= sw_csr_wdata[MS_MIE];
          if (w_accept) begin
            r_own <= 1'b1;
            if (w_is_mret) begin
              r_state <= S_M_RDEPC;
              r_ren   <= 1'b1;
              r_addr  <= CSR_MEPC;
            end else begin
              r_state   <= S_T_ENTER;
              r_unusual <= 1'b1;
              r_cause   <= w_cause;
              r_epc     <= inst_pc;
            end
          end
        end
        S_T_ENTER: begin
          r_tvec  <= csr_rdata;
          r_state <= S_T_RDST;
          r_ren   <= 1'b1;
          r_addr  <= CSR_MSTATUS;
        end
        S_T_RDST: begin
          r_st    <= csr_rdata;
          r_state <= S_T_WRST;
          r_wen   <= 1'b1;
          r_addr  <= CSR_MSTATUS;
          r_wdata <= {csr_rdata[DATA_LEN-1:13], ms_trap(csr_rdata[12:0])};
        end
        S_T_WRST: begin
          r_mie   <= 1'b0;
          r_state <= S_REDIR;
          r_redir <= 1'b1;
          r_rpc   <= {r_tvec[DATA_LEN-1:2], 2'b00};
        end
        S_M_RDEPC: begin
          r_epc_q <= csr_rdata;
          r_state <= S_M_RDST;
          r_ren   <= 1'b1;
          r_addr  <= CSR_MSTATUS;
        end
        S_M_RDST: begin
          r_st    <= csr_rdata;
          r_state <= S_M_WRST;
          r_wen   <= 1'b1;
          r_addr  <= CSR_MSTATUS;
          r_wdata <= {csr_rdata[DATA_LEN-1:13], ms_mret(csr_rdata[12:0])};
        end
        S_M_WRST: begin
          r_mie   <= r_st[MS_MPIE];
          r_state <= S_REDIR;
          r_redir <= 1'b1;
          r_rpc   <= r_epc_q;
        end
        S_REDIR: begin
          r_state <= S_IDLE;
          r_own   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_own   <= 1'b0;
        end
      endcase
    end
  end

  assign stall          = r_own | w_accept;
  assign csr_own        = r_own;
  assign unusual_flag   = r_unusual;
  assign cause          = r_cause;
  assign epc            = r_epc;
  assign csr_ren        = r_ren;
  assign csr_wen        = r_wen;
  assign csr_addr       = r_addr;
  assign csr_wdata      = r_wdata;
  assign redirect_valid = r_redir;
  assign redirect_pc    = r_rpc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl with a small behavioural csr block model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid, ecall, ebreak, illegal_inst, mret, timer_irq, sw_csr_wen;
  logic [31:0] inst_pc, sw_csr_wdata;
  logic [11:0] sw_csr_addr;
  logic        csr_own, unusual_flag, csr_ren, csr_wen, stall, redirect_valid;
  logic [31:0] cause, epc, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;

  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  logic [63:0] q_trap[$];
  logic [31:0] q_redir[$];
  int n_chk = 0, n_fail = 0, n_redir = 0, n_exp_redir = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .ecall(ecall), .ebreak(ebreak), .illegal_inst(illegal_inst), .mret(mret),
    .timer_irq(timer_irq), .sw_csr_wen(sw_csr_wen), .sw_csr_addr(sw_csr_addr),
    .sw_csr_wdata(sw_csr_wdata), .csr_own(csr_own), .unusual_flag(unusual_flag),
    .cause(cause), .epc(epc), .csr_ren(csr_ren), .csr_wen(csr_wen),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // csr block: trap strobe returns mtvec and latches mepc/mcause
  assign csr_rdata = unusual_flag ? m_mtvec :
                     (csr_ren && csr_addr == 12'h300) ? m_mstatus :
                     (csr_ren && csr_addr == 12'h341) ? m_mepc : 32'h0;

  always @(posedge clk) begin
    if (unusual_flag) begin
      m_mepc   <= epc;
      m_mcause <= cause;
    end
    if (csr_wen && csr_addr == 12'h300) m_mstatus <= csr_wdata;
    if (sw_csr_wen && sw_csr_addr == 12'h300) m_mstatus <= sw_csr_wdata;
    if (poke_en) begin
      case (poke_addr)
        12'h300: m_mstatus <= poke_data;
        12'h305: m_mtvec   <= poke_data;
        12'h341: m_mepc    <= poke_data;
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (unusual_flag) begin
        if (q_trap.size() == 0) check_eq("trap_unexpected", 1, 0);
        else begin
          logic [63:0] e;
          e = q_trap.pop_front();
          check_eq("cause", {32'h0, cause}, {32'h0, e[63:32]});
          check_eq("epc", {32'h0, epc}, {32'h0, e[31:0]});
        end
      end
      if (redirect_valid) begin
        n_redir++;
        if (q_redir.size() == 0) check_eq("redir_unexpected", 1, 0);
        else check_eq("redir_pc", {32'h0, redirect_pc}, {32'h0, q_redir.pop_front()});
      end
    end
  end

  task automatic clear_inputs();
    inst_valid = 0; ecall = 0; ebreak = 0; illegal_inst = 0; mret = 0; timer_irq = 0;
    sw_csr_wen = 0; sw_csr_addr = 12'h0; sw_csr_wdata = 32'h0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 0;
  endtask

  task automatic sw_write(input logic [31:0] d);
    @(negedge clk);
    sw_csr_wen = 1; sw_csr_addr = 12'h300; sw_csr_wdata = d;
    @(negedge clk);
    sw_csr_wen = 0;
  endtask

  // kind: 0 = no accept expected, 1 = trap, 2 = mret
  task automatic run_op(input string tag, input logic tirq, input logic ill, input logic ec,
                        input logic eb, input logic mr, input logic [31:0] pc, input int kind,
                        input logic [31:0] exp_cause, input logic [31:0] exp_pc,
                        input logic sw, input logic [31:0] swd, input bit inject);
    int lat;
    bit held;
    @(negedge clk);
    inst_valid = 1; timer_irq = tirq; illegal_inst = ill; ecall = ec; ebreak = eb; mret = mr;
    inst_pc = pc; sw_csr_wen = sw; sw_csr_addr = 12'h300; sw_csr_wdata = swd;
    if (kind == 1) q_trap.push_back({exp_cause, pc});
    if (kind != 0) begin
      q_redir.push_back(exp_pc);
      n_exp_redir++;
    end
    #1 check_eq({tag, "_stall_accept"}, stall, kind != 0);
    lat = 0;
    held = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      if (inject && k == 2) begin
        inst_valid = 1; ecall = 1; inst_pc = pc + 32'd4;
      end
      if (inject && k == 3) clear_inputs();
      if (kind == 0) break;
      if (!stall) held = 0;
      if (redirect_valid) begin
        lat = k;
        break;
      end
    end
    if (kind != 0) begin
      check_eq({tag, "_latency"}, lat, 4);
      check_eq({tag, "_stall_held"}, held, 1);
    end
    @(negedge clk);
    check_eq({tag, "_idle"}, {stall, csr_own}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    inst_pc = 0; poke_en = 0; poke_addr = 0; poke_data = 0;
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    poke(12'h305, 32'h8000_0100);
    poke(12'h300, 32'h0000_1808);
    #1;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_own", csr_own, 0);
    check_eq("rst_outs", {unusual_flag, csr_ren, csr_wen, redirect_valid}, 4'b0);
    check_eq("rst_vals", {cause, epc, redirect_pc}, 0);
    @(negedge clk);
    rst_n = 1;

    run_op("ecall", 0, 0, 1, 0, 0, 32'h8000_0010, 1, 32'd11, 32'h8000_0100, 0, 0, 0);
    check_eq("ecall_mstatus", m_mstatus, 32'h1880);
    check_eq("ecall_mepc", m_mepc, 32'h8000_0010);
    check_eq("ecall_mcause", m_mcause, 32'd11);

    poke(12'h341, 32'h8000_0014);
    run_op("mret", 0, 0, 0, 0, 1, 32'h8000_0018, 2, 0, 32'h8000_0014, 0, 0, 0);
    check_eq("mret_mstatus", m_mstatus, 32'h1888);

    run_op("irq_after_mret", 1, 0, 0, 0, 0, 32'h8000_0020, 1, 32'h8000_0007, 32'h8000_0100, 0, 0, 0);
    check_eq("irq_mstatus", m_mstatus, 32'h1880);

    run_op("irq_masked", 1, 0, 0, 0, 0, 32'h8000_0024, 0, 0, 0, 0, 0, 0);

    sw_write(32'h8);
    poke(12'h305, 32'h8000_0103);
    run_op("irq_prio", 1, 1, 1, 0, 0, 32'h8000_0028, 1, 32'h8000_0007, 32'h8000_0100, 0, 0, 0);
    check_eq("irq_prio_mstatus", m_mstatus, 32'h1880);

    run_op("ill_prio", 1, 1, 1, 0, 0, 32'h8000_002C, 1, 32'd2, 32'h8000_0100, 0, 0, 0);
    check_eq("ill_mstatus", m_mstatus, 32'h1800);

    run_op("ebreak", 0, 0, 0, 1, 1, 32'h8000_0030, 1, 32'd3, 32'h8000_0100, 0, 0, 0);

    run_op("snoop_same", 1, 0, 1, 0, 0, 32'h8000_0034, 1, 32'd11, 32'h8000_0100, 1, 32'h8, 0);
    check_eq("snoop_mstatus", m_mstatus, 32'h1880);

    run_op("inject", 0, 0, 1, 0, 0, 32'h8000_0038, 1, 32'd11, 32'h8000_0100, 0, 0, 1);
    check_eq("inject_mstatus", m_mstatus, 32'h1800);

    // reset in the middle of the mstatus write: no write, no redirect
    sw_write(32'h8);
    @(negedge clk);
    inst_valid = 1; ecall = 1; inst_pc = 32'h8000_003C;
    q_trap.push_back({32'd11, 32'h8000_003C});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
    end
    check_eq("wrst_wen", csr_wen, 1);
    #2 rst_n = 0;
    #1;
    check_eq("midrst_outs", {stall, csr_own, csr_wen, redirect_valid, unusual_flag}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_redir", n_redir, n_exp_redir);
    check_eq("midrst_mstatus", m_mstatus, 32'h8);

    run_op("post_rst", 1, 0, 1, 0, 0, 32'h8000_0040, 1, 32'd11, 32'h8000_0100, 0, 0, 0);
    check_eq("post_rst_mstatus", m_mstatus, 32'h1880);

    repeat (3) @(negedge clk);
    check_eq("q_trap_empty", q_trap.size(), 0);
    check_eq("q_redir_empty", q_redir.size(), 0);
    check_eq("n_redir", n_redir, n_exp_redir);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
